// File: rtl/axi4_defs_pkg.sv
// Shared AXI4 encodings and the FSM state type for the RAM-port to AXI4 initiator bridge.
package axi4_defs_pkg;

   localparam logic [1:0] AxiBurstFixed = 2'b00;
   localparam logic [1:0] AxiBurstIncr  = 2'b01;
   localparam logic [1:0] AxiBurstWrap  = 2'b10;

   localparam logic [1:0] AxiRespOkay   = 2'b00;
   localparam logic [1:0] AxiRespExokay = 2'b01;
   localparam logic [1:0] AxiRespSlverr = 2'b10;
   localparam logic [1:0] AxiRespDecerr = 2'b11;

   localparam logic [2:0] AxiSize4B     = 3'b010;

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StWaitB,
      StRead,
      StWaitR
   } axi_init_state_e;

endpackage

// File: rtl/ram_axi4_initiator.sv
// Single-beat AXI4 initiator driven from a simple RAM-style request port.
// Optional posted-write mode is enabled by defining RAM_AXI4_INITIATOR_POSTED_WRITE_EN.
module ram_axi4_initiator
   import axi4_defs_pkg::*;
#(
   parameter logic [3:0]  AXI_ID     = 4'd0,
   parameter int unsigned MAX_POSTED = 15
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic [3:0]  ram_wr_i,
   input  logic        ram_rd_i,
   input  logic [31:0] ram_addr_i,
   input  logic [31:0] ram_write_data_i,
   output logic        ram_accept_o,
   output logic        ram_ack_o,
   output logic        ram_error_o,
   output logic [31:0] ram_read_data_o,

   output logic        axi_awvalid_o,
   input  logic        axi_awready_i,
   output logic [31:0] axi_awaddr_o,
   output logic [3:0]  axi_awid_o,
   output logic [7:0]  axi_awlen_o,
   output logic [1:0]  axi_awburst_o,

   output logic        axi_wvalid_o,
   input  logic        axi_wready_i,
   output logic [31:0] axi_wdata_o,
   output logic [3:0]  axi_wstrb_o,
   output logic        axi_wlast_o,

   input  logic        axi_bvalid_i,
   output logic        axi_bready_o,
   input  logic [1:0]  axi_bresp_i,
   input  logic [3:0]  axi_bid_i,

   output logic        axi_arvalid_o,
   input  logic        axi_arready_i,
   output logic [31:0] axi_araddr_o,
   output logic [3:0]  axi_arid_o,
   output logic [7:0]  axi_arlen_o,
   output logic [1:0]  axi_arburst_o,

   input  logic        axi_rvalid_i,
   output logic        axi_rready_o,
   input  logic [31:0] axi_rdata_i,
   input  logic [1:0]  axi_rresp_i,
   input  logic [3:0]  axi_rid_i,
   input  logic        axi_rlast_i
);

   axi_init_state_e state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        arvalid_q, arvalid_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;

   logic wr_req, wr_ok, rd_ok, aw_hs, w_hs, wr_done, sticky_err;

   assign wr_req  = |ram_wr_i;
   assign aw_hs   = awvalid_q & axi_awready_i;
   assign w_hs    = wvalid_q & axi_wready_i;
   // Each channel counts as done if it already handshook or is handshaking now.
   assign wr_done = (state_q == StWrite) & (~awvalid_q | aw_hs) & (~wvalid_q | w_hs);

`ifdef RAM_AXI4_INITIATOR_POSTED_WRITE_EN
   localparam logic [3:0] MaxPosted = 4'(MAX_POSTED);

   logic [3:0] posted_q, posted_d;
   logic       sticky_q, sticky_d;
   logic       b_dec;

   assign axi_bready_o = 1'b1;
   assign b_dec        = axi_bvalid_i & (posted_q != 4'd0);
   assign wr_ok        = (posted_q != MaxPosted);
   assign rd_ok        = (posted_q == 4'd0);
   assign sticky_err   = sticky_q;

   always_comb begin
      posted_d = posted_q;
      if (wr_done && !b_dec) begin
         posted_d = posted_q + 4'd1;
      end else if (b_dec && !wr_done) begin
         posted_d = posted_q - 4'd1;
      end
      // A B error landing on an ack cycle is held for the following ack.
      sticky_d = (sticky_q & ~ack_d) | (b_dec & (axi_bresp_i != AxiRespOkay));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         posted_q <= 4'd0;
         sticky_q <= 1'b0;
      end else begin
         posted_q <= posted_d;
         sticky_q <= sticky_d;
      end
   end
`else
   logic unused_posted;

   assign axi_bready_o  = (state_q == StWaitB);
   assign wr_ok         = 1'b1;
   assign rd_ok         = 1'b1;
   assign sticky_err    = 1'b0;
   assign unused_posted = ^(4'(MAX_POSTED));
`endif

   // A simultaneous write and read is taken as the write alone.
   assign ram_accept_o = (state_q == StIdle) & (wr_req ? wr_ok : (ram_rd_i & rd_ok));

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ram_accept_o) begin
               addr_d = {ram_addr_i[31:2], 2'b00};
               if (wr_req) begin
                  wdata_d   = ram_write_data_i;
                  wstrb_d   = ram_wr_i;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = StWrite;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = StRead;
               end
            end
         end
         StWrite: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            if (wr_done) begin
`ifdef RAM_AXI4_INITIATOR_POSTED_WRITE_EN
               ack_d   = 1'b1;
               err_d   = sticky_err;
               state_d = StIdle;
`else
               state_d = StWaitB;
`endif
            end
         end
         StWaitB: begin
            if (axi_bvalid_i) begin
               ack_d   = 1'b1;
               err_d   = (axi_bresp_i != AxiRespOkay) | sticky_err;
               state_d = StIdle;
            end
         end
         StRead: begin
            if (axi_arready_i) begin
               arvalid_d = 1'b0;
               state_d   = StWaitR;
            end
         end
         StWaitR: begin
            if (axi_rvalid_i) begin
               rdata_d = axi_rdata_i;
               ack_d   = 1'b1;
               err_d   = (axi_rresp_i != AxiRespOkay) | sticky_err;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         rdata_q   <= 32'd0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   assign ram_ack_o       = ack_q;
   assign ram_error_o     = err_q;
   assign ram_read_data_o = rdata_q;

   assign axi_awvalid_o = awvalid_q;
   assign axi_awaddr_o  = addr_q;
   assign axi_awid_o    = AXI_ID;
   assign axi_awlen_o   = 8'd0;
   assign axi_awburst_o = AxiBurstIncr;

   assign axi_wvalid_o  = wvalid_q;
   assign axi_wdata_o   = wdata_q;
   assign axi_wstrb_o   = wstrb_q;
   assign axi_wlast_o   = 1'b1;

   assign axi_arvalid_o = arvalid_q;
   assign axi_araddr_o  = addr_q;
   assign axi_arid_o    = AXI_ID;
   assign axi_arlen_o   = 8'd0;
   assign axi_arburst_o = AxiBurstIncr;

   assign axi_rready_o  = (state_q == StWaitR);

   logic unused_ok;
   assign unused_ok = ^{axi_bid_i, axi_rid_i, axi_rlast_i, ram_addr_i[1:0]};

endmodule

// File: tb/tb_ram_axi4_initiator.sv
// Randomized self-checking bench for ram_axi4_initiator; expectations come from cycle-level
// latency arithmetic over the slave delays chosen per transaction.
module tb_ram_axi4_initiator;
   import axi4_defs_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic [3:0]  ram_wr_i = 4'h0;
   logic        ram_rd_i = 1'b0;
   logic [31:0] ram_addr_i = 32'h0;
   logic [31:0] ram_write_data_i = 32'h0;
   logic        ram_accept_o, ram_ack_o, ram_error_o;
   logic [31:0] ram_read_data_o;
   logic        axi_awvalid_o, axi_awready_i = 1'b0;
   logic [31:0] axi_awaddr_o;
   logic [3:0]  axi_awid_o;
   logic [7:0]  axi_awlen_o;
   logic [1:0]  axi_awburst_o;
   logic        axi_wvalid_o, axi_wready_i = 1'b0;
   logic [31:0] axi_wdata_o;
   logic [3:0]  axi_wstrb_o;
   logic        axi_wlast_o;
   logic        axi_bvalid_i = 1'b0, axi_bready_o;
   logic [1:0]  axi_bresp_i = 2'b00;
   logic [3:0]  axi_bid_i = 4'h0;
   logic        axi_arvalid_o, axi_arready_i = 1'b0;
   logic [31:0] axi_araddr_o;
   logic [3:0]  axi_arid_o;
   logic [7:0]  axi_arlen_o;
   logic [1:0]  axi_arburst_o;
   logic        axi_rvalid_i = 1'b0, axi_rready_o;
   logic [31:0] axi_rdata_i = 32'h0;
   logic [1:0]  axi_rresp_i = 2'b00;
   logic [3:0]  axi_rid_i = 4'h0;
   logic        axi_rlast_i = 1'b1;

   always #5 clk_i = ~clk_i;

   ram_axi4_initiator dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ram_wr_i(ram_wr_i), .ram_rd_i(ram_rd_i), .ram_addr_i(ram_addr_i),
      .ram_write_data_i(ram_write_data_i), .ram_accept_o(ram_accept_o),
      .ram_ack_o(ram_ack_o), .ram_error_o(ram_error_o), .ram_read_data_o(ram_read_data_o),
      .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
      .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o), .axi_awlen_o(axi_awlen_o),
      .axi_awburst_o(axi_awburst_o),
      .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i), .axi_wdata_o(axi_wdata_o),
      .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
      .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o), .axi_bresp_i(axi_bresp_i),
      .axi_bid_i(axi_bid_i),
      .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
      .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o), .axi_arlen_o(axi_arlen_o),
      .axi_arburst_o(axi_arburst_o),
      .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o), .axi_rdata_i(axi_rdata_i),
      .axi_rresp_i(axi_rresp_i), .axi_rid_i(axi_rid_i), .axi_rlast_i(axi_rlast_i)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] last_rdata = 32'h0;
   bit          pend_err = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_slave();
      axi_awready_i = 1'b0; axi_wready_i = 1'b0; axi_arready_i = 1'b0;
      axi_bvalid_i  = 1'b0; axi_rvalid_i = 1'b0;
      axi_bresp_i   = AxiRespOkay; axi_rresp_i = AxiRespOkay;
   endtask

   // Writes: d0 = AW ready delay, d1 = W ready delay, d2 = B delay.
   // Reads:  d0 = AR ready delay, d2 = R delay.
   task automatic run_txn(input bit is_wr, input logic [3:0] strb, input bit with_rd,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int d0, input int d1, input int d2, input logic [1:0] resp);
      int hs_at, b_at, r_at, ack_at, last, aw_n, w_n, ar_n;
      bit exp_err, posted;
      logic [31:0] exp_addr;
`ifdef RAM_AXI4_INITIATOR_POSTED_WRITE_EN
      posted = 1'b1;
`else
      posted = 1'b0;
`endif
      exp_addr = {addr[31:2], 2'b00};
      aw_n = 0; w_n = 0; ar_n = 0;
      hs_at = 1 + ((d0 > d1) ? d0 : d1);
      b_at  = hs_at + 1 + d2;
      r_at  = 2 + d0 + d2;
      if (is_wr) begin
         ack_at  = posted ? hs_at + 1 : b_at + 1;
         exp_err = posted ? pend_err : (resp != AxiRespOkay);
      end else begin
         ack_at  = r_at + 1;
         exp_err = (resp != AxiRespOkay) || pend_err;
      end
      last = (is_wr && b_at >= ack_at) ? b_at + 1 : ack_at + 1;

      @(negedge clk_i);
      clear_slave();
      ram_wr_i = is_wr ? strb : 4'h0;
      ram_rd_i = !is_wr || with_rd;
      ram_addr_i = addr;
      ram_write_data_i = data;
      #1 check_eq("accept", ram_accept_o, 1'b1);

      for (int k = 1; k <= last; k++) begin
         @(negedge clk_i);
         if (k < ack_at) begin
            ram_wr_i = 4'($urandom_range(0, 15));
            ram_rd_i = 1'b1;
         end else begin
            ram_wr_i = 4'h0;
            ram_rd_i = 1'b0;
         end
         axi_awready_i = is_wr && (k >= 1 + d0);
         axi_wready_i  = is_wr && (k >= 1 + d1);
         axi_arready_i = !is_wr && (k >= 1 + d0);
         axi_bvalid_i  = is_wr && (k == b_at);
         axi_bresp_i   = resp;
         axi_rvalid_i  = 1'b0;
         if (!is_wr && k == r_at) begin
            axi_rvalid_i = 1'b1; axi_rdata_i = data; axi_rresp_i = resp;
         end else if (is_wr && k < ack_at && $urandom_range(0, 1) == 1) begin
            axi_rvalid_i = 1'b1; axi_rdata_i = $urandom; axi_rresp_i = AxiRespSlverr;
         end
`ifndef RAM_AXI4_INITIATOR_POSTED_WRITE_EN
         if (!is_wr && k < ack_at && $urandom_range(0, 1) == 1) begin
            axi_bvalid_i = 1'b1; axi_bresp_i = AxiRespDecerr;
         end
`endif
         #1;
         if (k < ack_at) check_eq("busy_accept", ram_accept_o, 1'b0);
         check_eq("awvalid", axi_awvalid_o, is_wr && k <= 1 + d0);
         check_eq("wvalid", axi_wvalid_o, is_wr && k <= 1 + d1);
         check_eq("arvalid", axi_arvalid_o, !is_wr && k <= 1 + d0);
         check_eq("bready", axi_bready_o, posted || (is_wr && k > hs_at && k <= b_at));
         check_eq("rready", axi_rready_o, !is_wr && k >= 2 + d0 && k <= r_at);
         check_eq("ack", ram_ack_o, k == ack_at);
         check_eq("error", ram_error_o, k == ack_at && exp_err);
         if (axi_awvalid_o && axi_awready_i) begin
            aw_n++;
            check_eq("awaddr", axi_awaddr_o, exp_addr);
            check_eq("awid/len/burst", {axi_awid_o, axi_awlen_o, axi_awburst_o}, 14'h0001);
         end
         if (axi_wvalid_o && axi_wready_i) begin
            w_n++;
            check_eq("wdata", axi_wdata_o, data);
            check_eq("wstrb/wlast", {axi_wstrb_o, axi_wlast_o}, {strb, 1'b1});
         end
         if (axi_arvalid_o && axi_arready_i) begin
            ar_n++;
            check_eq("araddr", axi_araddr_o, exp_addr);
            check_eq("arid/len/burst", {axi_arid_o, axi_arlen_o, axi_arburst_o}, 14'h0001);
         end
         if (k == ack_at) begin
            if (!is_wr) last_rdata = data;
            check_eq("read_data", ram_read_data_o, last_rdata);
            pend_err = 1'b0;
         end
         if (posted && is_wr && k == b_at) pend_err = (resp != AxiRespOkay);
      end
      check_eq("aw_count", aw_n, is_wr);
      check_eq("w_count", w_n, is_wr);
      check_eq("ar_count", ar_n, !is_wr);
      clear_slave();
   endtask

   bit          r_wr, r_both;
   logic [3:0]  r_strb;
   logic [1:0]  r_resp;

   initial begin
      #2 rst_ni = 1'b0;
      #1;
      check_eq("rst_valids", {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o}, 3'b000);
      check_eq("rst_ack_err", {ram_ack_o, ram_error_o, ram_accept_o}, 3'b000);
      check_eq("rst_rdata", ram_read_data_o, 32'h0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i) rst_ni = 1'b1;

      run_txn(1'b1, 4'hF, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 0, 0, 0, AxiRespOkay);
      run_txn(1'b1, 4'h5, 1'b0, 32'h1000_0010, 32'hA5A5_0F0F, 4, 0, 1, AxiRespOkay);
      run_txn(1'b0, 4'h0, 1'b1, 32'h2000_0003, 32'h1234_5678, 2, 0, 0, AxiRespOkay);
      run_txn(1'b0, 4'h0, 1'b1, 32'h2000_0008, 32'h0BAD_CAFE, 0, 0, 1, AxiRespSlverr);
      run_txn(1'b1, 4'h3, 1'b1, 32'h3000_0002, 32'h0102_0304, 0, 2, 0, AxiRespDecerr);

      for (int n = 0; n < 40; n++) begin
         r_wr   = 1'($urandom_range(0, 1));
         r_both = 1'($urandom_range(0, 1));
         r_strb = 4'($urandom_range(1, 15));
         r_resp = 2'($urandom_range(0, 3));
         run_txn(r_wr, r_strb, r_both, $urandom, $urandom, $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), r_resp);
      end

      // Asynchronous reset while a write is stalled on AW/W.
      @(negedge clk_i);
      ram_wr_i = 4'hF; ram_addr_i = 32'h5000_0000;
      #1 check_eq("abort_accept", ram_accept_o, 1'b1);
      @(negedge clk_i);
      ram_wr_i = 4'h0;
      #1 check_eq("abort_pre", {axi_awvalid_o, axi_wvalid_o}, 2'b11);
      #2 rst_ni = 1'b0;
      #1 check_eq("abort_valids", {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o}, 3'b000);
      @(negedge clk_i) rst_ni = 1'b1;
      pend_err = 1'b0;
      axi_bvalid_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         #1 check_eq("abort_quiet", {ram_ack_o, axi_awvalid_o, axi_wvalid_o}, 3'b000);
      end
      axi_bvalid_i = 1'b0;
      run_txn(1'b0, 4'h0, 1'b0, 32'h6000_0004, 32'h7777_1111, 1, 0, 1, AxiRespOkay);

`ifdef RAM_AXI4_INITIATOR_POSTED_WRITE_EN
      // B held off: fifteen writes complete, the sixteenth stalls.
      axi_awready_i = 1'b1; axi_wready_i = 1'b1;
      for (int n = 0; n <= 15; n++) begin
         @(negedge clk_i);
         ram_wr_i = 4'hF; ram_addr_i = 32'(n * 4); ram_write_data_i = $urandom;
         #1 check_eq("post_accept", ram_accept_o, n < 15);
         @(negedge clk_i) ram_wr_i = 4'h0;
         @(negedge clk_i);
         #1 check_eq("post_ack", {ram_ack_o, ram_error_o}, {n < 15, 1'b0});
      end
      // One B drains, then a write completes on the same cycle as another B.
      @(negedge clk_i) axi_bvalid_i = 1'b1;
      @(negedge clk_i);
      axi_bvalid_i = 1'b0; ram_wr_i = 4'hF;
      #1 check_eq("post_reopen", ram_accept_o, 1'b1);
      @(negedge clk_i);
      ram_wr_i = 4'h0; axi_bvalid_i = 1'b1;
      @(negedge clk_i);
      axi_bvalid_i = 1'b0; ram_wr_i = 4'hF;
      #1 check_eq("post_same_cycle", {ram_ack_o, ram_accept_o}, 2'b11);
      @(negedge clk_i) ram_wr_i = 4'h0;
      @(negedge clk_i);
      ram_wr_i = 4'hF;
      #1 check_eq("post_full", {ram_ack_o, ram_accept_o}, 2'b10);
      @(negedge clk_i);
      ram_wr_i = 4'h0; ram_rd_i = 1'b1; ram_addr_i = 32'h4000_0008; axi_arready_i = 1'b1;
      for (int m = 0; m < 15; m++) begin
         axi_bvalid_i = 1'b1;
         axi_bresp_i = (m == 7) ? AxiRespSlverr : AxiRespOkay;
         #1 check_eq("post_rd_stall", ram_accept_o, 1'b0);
         @(negedge clk_i);
      end
      axi_bvalid_i = 1'b0;
      #1 check_eq("post_rd_accept", ram_accept_o, 1'b1);
      @(negedge clk_i) ram_rd_i = 1'b0;
      @(negedge clk_i);
      axi_arready_i = 1'b0; axi_rvalid_i = 1'b1; axi_rdata_i = 32'hCAFE_F00D;
      axi_rresp_i = AxiRespOkay;
      @(negedge clk_i);
      axi_rvalid_i = 1'b0;
      #1 check_eq("post_rd_ack", {ram_ack_o, ram_error_o}, 2'b11);
      check_eq("post_rd_data", ram_read_data_o, 32'hCAFE_F00D);
      clear_slave();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
